// File: rtl/eth_frame_tx.sv
// 10BASE-T frame transmitter: 256-byte frame buffer, Manchester serializer with
// preamble/SFD/FCS/TP_IDL framing, normal link pulses while idle, and an activity LED.
module eth_frame_tx #(
    parameter int FRAME_LEN  = 60,
    parameter int NLP_PERIOD = 320000,
    parameter int NLP_WIDTH  = 2,
    parameter int TPIDL_LEN  = 6,
    parameter int LED_HOLD   = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_en,
    input  logic [7:0] w_addr,
    input  logic [7:0] w_data,
    input  logic       w_en,
    input  logic       start,
    output logic       tx,
    output logic       tx_led,
    output logic       busy
);

    localparam int NLP_W = $clog2(NLP_PERIOD + 1);
    localparam int PW_W  = $clog2(NLP_WIDTH + 1);
    localparam int TP_W  = $clog2(TPIDL_LEN + 1);
    localparam int LED_W = $clog2(LED_HOLD + 2);
    localparam logic [31:0] CRC_POLY = 32'hEDB88320;

    typedef enum logic [2:0] {IDLE, PRE, DATA, FCS, TPIDL} state_t;
    state_t state_reg, state_next;

    logic [7:0]       mem [256];
    logic [7:0]       rd_data_reg;
    logic [8:0]       data_idx_reg;
    logic [7:0]       shift_reg;
    logic [2:0]       bit_idx_reg;
    logic             half_reg;
    logic [2:0]       byte_cnt_reg;
    logic [31:0]      crc_reg;
    logic [NLP_W-1:0] nlp_cnt_reg;
    logic [PW_W-1:0]  pulse_cnt_reg;
    logic [TP_W-1:0]  tpidl_cnt_reg;
    logic [LED_W-1:0] led_cnt_reg;
    logic             tx_reg, tx_led_reg, busy_reg;

    logic        cur_bit, byte_done, nlp_due, tpidl_done;
    logic [31:0] crc_step;
    logic [7:0]  next_byte;
    logic [7:0]  fcs_byte [4];

    // Frame buffer; the read address always points at the next data byte to load,
    // so the registered read is ready long before the serializer needs it.
    always_ff @(posedge clk) begin
        if (clk_en) begin
            if (w_en) mem[w_addr] <= w_data;
            rd_data_reg <= mem[data_idx_reg[7:0]];
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_fcs
        assign fcs_byte[gi] = ~crc_reg[8*gi +: 8];
    end

    assign cur_bit    = shift_reg[bit_idx_reg];
    assign byte_done  = half_reg && (bit_idx_reg == 3'd7);
    assign nlp_due    = (nlp_cnt_reg == NLP_W'(NLP_PERIOD - 1));
    assign tpidl_done = (tpidl_cnt_reg == TP_W'(TPIDL_LEN));
    assign crc_step   = {1'b0, crc_reg[31:1]} ^ ((crc_reg[0] ^ cur_bit) ? CRC_POLY : 32'h0);

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:    if (start) state_next = PRE;
            PRE:     if (byte_done && byte_cnt_reg == 3'd7) state_next = DATA;
            DATA:    if (byte_done && data_idx_reg == 9'(FRAME_LEN)) state_next = FCS;
            FCS:     if (byte_done && byte_cnt_reg == 3'd3) state_next = TPIDL;
            TPIDL:   if (tpidl_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Byte that follows the one currently being shifted out.
    always_comb begin
        next_byte = 8'h55;
        unique case (state_reg)
            PRE:     next_byte = (byte_cnt_reg == 3'd7) ? rd_data_reg :
                                 (byte_cnt_reg == 3'd6) ? 8'hD5 : 8'h55;
            DATA:    next_byte = (data_idx_reg == 9'(FRAME_LEN)) ? fcs_byte[0] : rd_data_reg;
            FCS:     next_byte = fcs_byte[byte_cnt_reg[1:0] + 2'd1];
            default: next_byte = 8'h55;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else if (clk_en) state_reg <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_idx_reg  <= '0;
            shift_reg     <= '0;
            bit_idx_reg   <= '0;
            half_reg      <= 1'b0;
            byte_cnt_reg  <= '0;
            crc_reg       <= '0;
            nlp_cnt_reg   <= '0;
            pulse_cnt_reg <= '0;
            tpidl_cnt_reg <= '0;
            led_cnt_reg   <= '0;
            tx_reg        <= 1'b0;
            tx_led_reg    <= 1'b0;
            busy_reg      <= 1'b0;
        end else if (clk_en) begin
            if (state_reg != IDLE) nlp_cnt_reg <= '0;
            unique case (state_reg)
                IDLE: begin
                    if (start) begin
                        // A frame beats a due link pulse and cuts a running one short.
                        busy_reg      <= 1'b1;
                        tx_led_reg    <= 1'b1;
                        tx_reg        <= 1'b0;
                        crc_reg       <= '1;
                        shift_reg     <= 8'h55;
                        bit_idx_reg   <= '0;
                        half_reg      <= 1'b0;
                        byte_cnt_reg  <= '0;
                        data_idx_reg  <= '0;
                        nlp_cnt_reg   <= '0;
                        pulse_cnt_reg <= '0;
                    end else begin
                        if (nlp_due) begin
                            nlp_cnt_reg   <= '0;
                            tx_reg        <= 1'b1;
                            pulse_cnt_reg <= PW_W'(NLP_WIDTH - 1);
                        end else begin
                            nlp_cnt_reg <= nlp_cnt_reg + 1'b1;
                            if (pulse_cnt_reg != '0) begin
                                tx_reg        <= 1'b1;
                                pulse_cnt_reg <= pulse_cnt_reg - 1'b1;
                            end else begin
                                tx_reg <= 1'b0;
                            end
                        end
                        if (led_cnt_reg != '0) begin
                            led_cnt_reg <= led_cnt_reg - 1'b1;
                            if (led_cnt_reg == LED_W'(1)) tx_led_reg <= 1'b0;
                        end
                    end
                end
                PRE, DATA, FCS: begin
                    tx_reg   <= half_reg ? cur_bit : ~cur_bit;
                    half_reg <= ~half_reg;
                    if (state_reg == DATA && !half_reg) crc_reg <= crc_step;
                    if (half_reg) bit_idx_reg <= bit_idx_reg + 3'd1;
                    if (byte_done) begin
                        shift_reg     <= next_byte;
                        byte_cnt_reg  <= (state_next != state_reg) ? 3'd0 : byte_cnt_reg + 3'd1;
                        tpidl_cnt_reg <= '0;
                        if (state_reg == DATA || state_next == DATA)
                            data_idx_reg <= data_idx_reg + 9'd1;
                    end
                end
                TPIDL: begin
                    if (tpidl_done) begin
                        tx_reg      <= 1'b0;
                        busy_reg    <= 1'b0;
                        led_cnt_reg <= LED_W'(LED_HOLD);
                        tx_led_reg  <= (LED_HOLD != 0);
                    end else begin
                        tx_reg        <= 1'b1;
                        tpidl_cnt_reg <= tpidl_cnt_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign tx     = tx_reg;
    assign tx_led = tx_led_reg;
    assign busy   = busy_reg;

endmodule

// File: tb/tb_eth_frame_tx.sv
// Bench for eth_frame_tx: decodes the Manchester line back into bytes and compares
// them against a queue of expected frame bytes; also checks NLP, LED, busy and reset.
module tb_eth_frame_tx;

    localparam int FL     = 9;
    localparam int NLP_P  = 100;
    localparam int NLP_W  = 2;
    localparam int TP_LEN = 6;
    localparam int LED_H  = 50;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clk_en = 1'b0;
    logic [7:0] w_addr = '0;
    logic [7:0] w_data = '0;
    logic       w_en = 1'b0;
    logic       start = 1'b0;
    logic       tx, tx_led, busy;

    int         n_checks = 0;
    int         n_errors = 0;
    int         frame_no = 0;
    logic [7:0] mem_model [256];
    logic [7:0] exp_q [$];

    eth_frame_tx #(
        .FRAME_LEN(FL), .NLP_PERIOD(NLP_P), .NLP_WIDTH(NLP_W),
        .TPIDL_LEN(TP_LEN), .LED_HOLD(LED_H)
    ) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .w_addr(w_addr), .w_data(w_data),
        .w_en(w_en), .start(start), .tx(tx), .tx_led(tx_led), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One tick, sometimes preceded by a non-tick clock edge.
    task automatic tick();
        if ($urandom_range(0, 2) == 0) begin
            clk_en = 1'b0;
            @(posedge clk); #1;
        end
        clk_en = 1'b1;
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] fcs_of(input logic [7:0] d [FL]);
        logic [31:0] c = 32'hFFFFFFFF;
        logic        fb;
        for (int i = 0; i < FL; i++)
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ d[i][b];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB88320;
            end
        return ~c;
    endfunction

    task automatic run_frame(input bit hold_start, input bit late_write,
                             input logic [7:0] late_val, input bit check_manch);
        logic [7:0]  fr [FL];
        logic [31:0] fcs;
        logic [15:0] hbits = '0;
        logic [7:0]  acc = '0;
        logic [7:0]  exp_b;
        logic        first = 1'b0;
        logic        bad = 1'b0;
        if (late_write) mem_model[FL-1] = late_val;
        for (int i = 0; i < FL; i++) fr[i] = mem_model[i];
        fcs = fcs_of(fr);
        for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        for (int i = 0; i < FL; i++) exp_q.push_back(fr[i]);
        for (int i = 0; i < 4; i++) exp_q.push_back(fcs[8*i +: 8]);

        start = 1'b1;
        w_en  = 1'b0;
        tick();
        chk("start_busy", busy, 1);
        chk("start_tx", tx, 0);
        chk("start_led", tx_led, 1);
        if (!hold_start) start = 1'b0;

        for (int h = 0; h < (8 + FL + 4) * 16; h++) begin
            if (late_write && h == 20) begin
                w_en = 1'b1; w_addr = 8'(FL - 1); w_data = late_val;
            end else begin
                w_en = 1'b0;
            end
            tick();
            if (h >= 128 && h < 144) hbits[h-128] = tx;
            if (h % 2 == 0) first = tx;
            else begin
                acc[(h % 16) / 2] = tx;
                if (first == tx) bad = 1'b1;
            end
            if (h % 16 == 15) begin
                exp_b = exp_q.pop_front();
                chk("frame_byte", {23'd0, bad, acc}, {24'd0, exp_b});
                bad = 1'b0;
            end
            if (h == (8 + FL + 4) * 16 - 1) chk("frame_busy", busy, 1);
        end
        if (check_manch) chk("manch_0x01", {16'd0, hbits}, 32'h5556);

        for (int i = 0; i < TP_LEN; i++) begin
            tick();
            chk("tpidl_tx", tx, 1);
            chk("tpidl_busy", busy, 1);
        end
        tick();
        chk("end_busy", busy, 0);
        chk("end_tx", tx, 0);
        frame_no++;
        $display("frame %0d: %0d bytes decoded, fcs %08h", frame_no, 8 + FL + 4, fcs);
    endtask

    // Idle ticks right after a frame ends: link pulses and LED stretch.
    task automatic idle_watch(input int n, input bit do_wr, input logic [7:0] wa,
                              input logic [7:0] wd);
        for (int k = 1; k <= n; k++) begin
            if (do_wr && k == 10) begin
                w_en = 1'b1; w_addr = wa; w_data = wd; mem_model[wa] = wd;
            end else begin
                w_en = 1'b0;
            end
            tick();
            chk("nlp_tx", tx, (k >= NLP_P && (k % NLP_P) < NLP_W) ? 1 : 0);
            if (k == LED_H - 1) chk("led_hold", tx_led, 1);
            if (k == LED_H) chk("led_off", tx_led, 0);
        end
        w_en = 1'b0;
        $display("idle: %0d ticks watched", n);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_tx", tx, 0);
        chk("rst_busy", busy, 0);
        chk("rst_led", tx_led, 0);

        for (int i = 0; i < FL; i++) begin
            w_en = 1'b1; w_addr = 8'(i); w_data = 8'h31 + 8'(i);
            mem_model[i] = 8'h31 + 8'(i);
            tick();
        end
        w_en = 1'b0;

        run_frame(1'b0, 1'b0, 8'h00, 1'b0);        // "123456789" check vector
        idle_watch(299, 1'b1, 8'h00, 8'h01);        // next tick is an NLP wrap
        run_frame(1'b1, 1'b1, 8'hA5, 1'b1);        // start on wrap, late write, start held
        run_frame(1'b0, 1'b0, 8'h00, 1'b0);        // accepted the tick after busy falls
        idle_watch(100, 1'b0, 8'h00, 8'h00);        // ends on first pulse tick
        run_frame(1'b0, 1'b0, 8'h00, 1'b0);        // start truncates the pulse

        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (200) tick();
        clk_en = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_tx", tx, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_led", tx_led, 0);
        exp_q.delete();
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("post_rst_tx", tx, 0);
            chk("post_rst_busy", busy, 0);
        end
        $display("reset: aborted frame, line quiet for 20 ticks");
        run_frame(1'b0, 1'b0, 8'h00, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

endmodule
